alu_nibble_sequencer: RTL
=========================

# alu_nibble_sequencer

Multi-cycle controller that runs 4·NIBBLES-bit arithmetic and logic operations on the team's 4-bit combinational ALU, one nibble per clock, least-significant nibble first. For add and subtract it chains the ALU carry/borrow between nibbles. It accepts one request at a time over a valid/ready handshake and drives the ALU's A/B/Cin/S/M inputs directly. It returns the assembled result over a second valid/ready handshake. It sits between the datapath issue logic and the single shared ALU instance.

## Interface
- NIBBLES, default 4: operand width in nibbles; W = 4·NIBBLES. Legal values are 2..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a, req_b  in  W  operands.
- req_m  in  1  ALU mode: 0 = logic, 1 = arithmetic.
- req_s  in  2  ALU select. Logic mode: 00 ~A, 01 A&B, 10 A|B, 11 A^B. Arithmetic mode: 00 add, 01 subtract, 1x unsupported.
- req_cin  in  1  initial carry (add) or initial borrow (subtract).
- alu_a, alu_b  out  4  current nibble of each operand, to the ALU.
- alu_cin  out  1  ALU carry/borrow input.
- alu_s  out  2  ALU select.
- alu_m  out  1  ALU mode.
- alu_f  in  4  ALU result nibble.
- alu_cn  in  1  ALU carry/borrow output.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_f  out  W  assembled result.
- rsp_cn  out  1  final carry (add), final borrow (subtract), or 0.
- rsp_zero, rsp_ovf  out  1 each  flags; present only with ALU_SEQ_FLAGS_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - req_ready = 1.
  - On req_valid && req_ready, latch req_a, req_b, req_m, req_s. Set carry register ← (req_m ? req_cin : 0) and nibble counter ← 0. Go to RUN.
- **RUN**
  - alu_a = a_reg[4·cnt +: 4], alu_b = b_reg[4·cnt +: 4], alu_cin = carry register, alu_s/alu_m = latched values.
  - Each edge: result[4·cnt +: 4] ← alu_f and carry ← (m ? alu_cn : 0).
  - When cnt == NIBBLES-1, go to DONE. Otherwise cnt ← cnt+1.
- **DONE**
  - rsp_valid = 1. rsp_f and rsp_cn hold stable.
  - On rsp_ready, go to IDLE.
- rsp_cn = carry register after the last nibble.
- Unsupported arithmetic selects (M=1, S=1x) are sequenced normally; the ALU returns 0, so rsp_f = 0 and rsp_cn = 0.
- Logic ops force alu_cin = 0 on every nibble and give rsp_cn = 0.
- In IDLE and DONE, alu_a, alu_b, alu_cin, alu_s and alu_m are all driven to 0.
- req_valid in RUN or DONE is ignored (req_ready = 0). The requester must hold its request until accepted.
- **Reset values:** state IDLE, cnt 0, carry 0, rsp_f 0, rsp_cn 0, rsp_valid 0. req_ready = 0 while rst is high.
- **Reset mid-operation:** the in-flight operation is dropped with no response. The block is in IDLE on the cycle after rst deasserts.

## Timing
- Request accepted at edge k.
- RUN spans the cycles between edges k and k+NIBBLES.
- rsp_valid rises immediately after edge k+NIBBLES: NIBBLES cycles of latency from acceptance.
- rsp_valid is held through any number of rsp_ready-low cycles.
- With rsp_ready high, one cycle is spent in DONE, then IDLE. Minimum request-to-request spacing is NIBBLES+2 cycles.
- The ALU path is combinational: alu_* outputs → alu_f/alu_cn is a single-cycle path, captured on the next edge.

## Configuration
- ALU_SEQ_FLAGS_EN defined: adds rsp_zero and rsp_ovf, both registered with rsp_f and reset to 0.
  - rsp_zero = (rsp_f == 0).
  - rsp_ovf is signed overflow, computed from operand/result MSBs at the final nibble:
    - add: a_msb == b_msb and f_msb != a_msb.
    - subtract: a_msb != b_msb and f_msb != a_msb.
    - logic or unsupported ops: 0.
- ALU_SEQ_FLAGS_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
All cases use NIBBLES = 4.
- **Add:** 0x1234 + 0x0FFF, cin 0 → rsp_f 0x2233, rsp_cn 0. rsp_valid exactly 4 cycles after the accepting edge. alu_a sequence 4,3,2,1.
- **Add with wrap and overflow:**
  - 0xFFFF + 0x0001 → 0x0000, rsp_cn 1, rsp_zero 1.
  - 0x7FFF + 0x0001 → 0x8000, rsp_cn 0, rsp_ovf 1 (flags only with the macro).
- **Subtract:**
  - 0x1000 − 0x0001, cin 0 → 0x0FFF, rsp_cn 0; alu_cin sequence 0,1,1,1.
  - 0x0001 − 0x0002 → 0xFFFF, rsp_cn 1.
- **Logic:** 0xA5A5 ^ 0x0FF0 (M=0, S=11) → 0xAA55, rsp_cn 0, alu_cin 0 on all nibbles. ~0x00FF (S=00) → 0xFF00.
- **Backpressure:**
  - rsp_ready held low 3 cycles in DONE → rsp_f and rsp_valid stable, req_ready 0.
  - req_valid pulsed during RUN is not accepted.
  - After rsp_ready, the next request is accepted from IDLE.
- **Reset mid-RUN:** rst asserted at nibble 2 → IDLE next cycle, rsp_valid 0, rsp_f 0. No response is ever produced for the dropped request. A fresh 0x0003 + 0x0004 then returns 0x0007.

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
// Nibble-serial sequencer driving a shared 4-bit ALU, LS nibble first.
// Optional rsp_zero/rsp_ovf flags under `ALU_SEQ_FLAGS_EN.
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [4*NIBBLES-1:0] req_a,
  input  logic [4*NIBBLES-1:0] req_b,
  input  logic                 req_m,
  input  logic [1:0]           req_s,
  input  logic                 req_cin,
  output logic [3:0]           alu_a,
  output logic [3:0]           alu_b,
  output logic                 alu_cin,
  output logic [1:0]           alu_s,
  output logic                 alu_m,
  input  logic [3:0]           alu_f,
  input  logic                 alu_cn,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [4*NIBBLES-1:0] rsp_f,
  output logic                 rsp_cn
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                 rsp_zero,
  output logic                 rsp_ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic           m_reg;
  logic [1:0]     s_reg;
  logic           run;
  logic           last;
  logic [CW+1:0]  idx;

  assign run  = (state == RUN);
  assign last = (cnt == CW'(NIBBLES - 1));
  assign idx  = {cnt, 2'b00};

  assign req_ready = (state == IDLE) && !rst;

  // Outside RUN the shared ALU sees all-zero inputs.
  assign alu_a   = run ? a_reg[idx +: 4] : 4'h0;
  assign alu_b   = run ? b_reg[idx +: 4] : 4'h0;
  assign alu_cin = run & m_reg & carry;
  assign alu_s   = run ? s_reg : 2'b00;
  assign alu_m   = run & m_reg;

`ifdef ALU_SEQ_FLAGS_EN
  logic [W-1:0] full;
  logic         a_msb;
  logic         b_msb;
  logic         f_msb;
  logic         ovf;

  assign full  = {alu_f, rsp_f[W-5:0]};
  assign a_msb = a_reg[W-1];
  assign b_msb = b_reg[W-1];
  assign f_msb = alu_f[3];

  always_comb begin
    ovf = 1'b0;
    if (m_reg) begin
      unique case (1'b1)
        (s_reg == 2'b00): ovf = (a_msb == b_msb) && (f_msb != a_msb);
        (s_reg == 2'b01): ovf = (a_msb != b_msb) && (f_msb != a_msb);
        default:          ovf = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_zero <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (run && last) begin
      rsp_zero <= (full == '0);
      rsp_ovf  <= ovf;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      m_reg     <= 1'b0;
      s_reg     <= 2'b00;
      rsp_f     <= '0;
      rsp_cn    <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            a_reg <= req_a;
            b_reg <= req_b;
            m_reg <= req_m;
            s_reg <= req_s;
            carry <= req_m & req_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          rsp_f[idx +: 4] <= alu_f;
          carry           <= m_reg & alu_cn;
          if (last) begin
            rsp_cn    <= m_reg & alu_cn;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
